// File: rtl/pcpu_ctrl_pkg.sv
// Shared types and constants for the pcpu pipeline hazard controller.
package pcpu_ctrl_pkg;

  // Data-memory handshake sequencer states
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // EX-stage operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one EX-stage source register.
// The MEM-stage result is younger than the WB-stage result, so it takes priority.
module forward_unit
  import pcpu_ctrl_pkg::*;
(
  input  logic [4:0] i_ex_rs,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_regwrite,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_regwrite,
  output logic [1:0] o_fwd
);

  logic w_mem_hit;
  logic w_wb_hit;

  // x0 is hardwired to zero and is never forwarded
  assign w_mem_hit = i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs);
  assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  != 5'd0) && (i_wb_rd  == i_ex_rs);

  // Priority select: MEM result first, then WB result, else register file
  always_comb begin
    o_fwd = FWD_RF;
    if (w_mem_hit)     o_fwd = FWD_MEM;
    else if (w_wb_hit) o_fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage pcpu core: stalls, flushes,
// operand forwarding, data-memory handshake sequencing and event counters.
module hazard_ctrl
  import pcpu_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       EX_rs1,
  input  logic [4:0]       EX_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic [4:0]       MEM_rd,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic [4:0]       WB_rd,
  input  logic             WB_RegWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             bubble_MEM_WB,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_mem_timeout;

  logic w_mem_acc;
  logic w_mem_stall;
  logic w_load_use;
  logic w_branch;
  logic w_lu_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Hazard detection; a memory stall freezes the front end, so branch and
  // load-use actions wait until the access completes
  assign w_mem_acc   = MEM_MemRead | MEM_MemWrite;
  assign w_mem_stall = w_mem_acc & ~dmem_ready;
  assign w_load_use  = EX_MemRead && (EX_rd != 5'd0) &&
                       ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));
  assign w_branch    = EX_branch_taken & ~w_mem_stall;
  // A taken branch squashes the dependent instruction, so no load-use stall
  assign w_lu_stall  = w_load_use & ~w_mem_stall & ~EX_branch_taken;

  assign dmem_req      = w_mem_acc;
  assign stall_PC      = w_mem_stall | w_lu_stall;
  assign stall_IF_ID   = w_mem_stall | w_lu_stall;
  assign stall_ID_EX   = w_mem_stall;
  assign stall_EX_MEM  = w_mem_stall;
  assign bubble_MEM_WB = w_mem_stall;
  assign flush_IF_ID   = w_branch;
  assign flush_ID_EX   = w_branch | w_lu_stall;

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_mem_timeout;

  forward_unit u_fwd_a (
    .i_ex_rs        (EX_rs1),
    .i_mem_rd       (MEM_rd),
    .i_mem_regwrite (MEM_RegWrite),
    .i_wb_rd        (WB_rd),
    .i_wb_regwrite  (WB_RegWrite),
    .o_fwd          (ForwardA)
  );

  forward_unit u_fwd_b (
    .i_ex_rs        (EX_rs2),
    .i_mem_rd       (MEM_rd),
    .i_mem_regwrite (MEM_RegWrite),
    .i_wb_rd        (WB_rd),
    .i_wb_regwrite  (WB_RegWrite),
    .o_fwd          (ForwardB)
  );

  // Next-state logic for the memory handshake sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (w_mem_stall) w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready || !w_mem_acc) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  // Wait-cycle counter (saturating) and sticky timeout flag; the FSM keeps
  // waiting after the flag is raised
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (w_state_nxt == RUN)
        r_wait_cnt <= '0;
      else if ((r_state == MEM_WAIT) && (r_wait_cnt != WAIT_W'(MAX_WAIT)))
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if ((r_state == MEM_WAIT) && (r_wait_cnt >= WAIT_W'(MAX_WAIT - 1)))
        r_mem_timeout <= 1'b1;
    end
  end

  // Saturating stall and flush event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_mem_stall | w_lu_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_branch)                 r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MAX_WAIT=4, CNT_W=4).
module tb_hazard_ctrl;
  import pcpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] ID_rs1, ID_rs2, EX_rs1, EX_rs2, EX_rd, MEM_rd, WB_rd;
  logic       EX_MemRead, EX_branch_taken, MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
  logic       WB_RegWrite, dmem_ready;
  logic       dmem_req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
  logic       flush_IF_ID, flush_ID_EX, bubble_MEM_WB, mem_timeout;
  logic [1:0] ForwardA, ForwardB;
  logic [3:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2),
    .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_branch_taken(EX_branch_taken),
    .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite), .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .bubble_MEM_WB(bubble_MEM_WB), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control/stall/flush outputs packed as
  // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, bubble, flush_IF_ID, flush_ID_EX, dmem_req}
  function automatic logic [31:0] ctl();
    return {24'd0, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
            bubble_MEM_WB, flush_IF_ID, flush_ID_EX, dmem_req};
  endfunction

  task automatic idle_inputs();
    ID_rs1 = 0; ID_rs2 = 0; EX_rs1 = 0; EX_rs2 = 0; EX_rd = 0; MEM_rd = 0; WB_rd = 0;
    EX_MemRead = 0; EX_branch_taken = 0; MEM_RegWrite = 0; MEM_MemRead = 0;
    MEM_MemWrite = 0; WB_RegWrite = 0; dmem_ready = 0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #12;
    // Reset state
    chk("rst_state", dut.r_state, RUN);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_ctl", ctl(), 8'b0000_0000);
    reset_n = 1'b1;
    tick();

    // Load-use: load x5 in EX, ID reads x5 on rs2
    EX_MemRead = 1; EX_rd = 5; ID_rs2 = 5; ID_rs1 = 7;
    #1 chk("lu_ctl", ctl(), 8'b1100_0010);
    tick();
    chk("lu_stall_cnt", stall_cnt, 1);
    // Load to x0 never causes a stall
    EX_rd = 0; ID_rs1 = 0; ID_rs2 = 0;
    #1 chk("lu_x0_ctl", ctl(), 8'b0000_0000);
    tick();
    chk("lu_x0_stall_cnt", stall_cnt, 1);
    EX_MemRead = 0;

    // Forwarding
    MEM_RegWrite = 1; MEM_rd = 3; WB_RegWrite = 1; WB_rd = 3; EX_rs1 = 3; EX_rs2 = 4;
    #1 chk("fwd_a_mem_prio", ForwardA, 2'b10);
    chk("fwd_b_none", ForwardB, 2'b00);
    MEM_rd = 9;
    #1 chk("fwd_a_wb", ForwardA, 2'b01);
    MEM_RegWrite = 0; MEM_rd = 4; WB_rd = 4;
    #1 chk("fwd_b_wb_memoff", ForwardB, 2'b01);
    MEM_RegWrite = 1; MEM_rd = 0; WB_rd = 0; EX_rs1 = 0; EX_rs2 = 0;
    #1 chk("fwd_a_x0", ForwardA, 2'b00);
    chk("fwd_b_x0", ForwardB, 2'b00);
    MEM_RegWrite = 0; WB_RegWrite = 0;
    tick();

    // Branch with simultaneous load-use: branch wins
    EX_MemRead = 1; EX_rd = 5; ID_rs1 = 5; EX_branch_taken = 1;
    #1 chk("br_lu_ctl", ctl(), 8'b0000_0110);
    tick();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);
    EX_MemRead = 0; EX_branch_taken = 0; EX_rd = 0; ID_rs1 = 0;

    // Memory stall 3 cycles with a pending branch: mem stall wins
    MEM_MemRead = 1; dmem_ready = 0; EX_branch_taken = 1;
    MEM_RegWrite = 1; MEM_rd = 6; EX_rs2 = 6;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ms_ctl", ctl(), 8'b1111_1001);
      chk("ms_fwd_b", ForwardB, 2'b10);
      tick();
      chk("ms_state", dut.r_state, MEM_WAIT);
      chk("ms_stall_cnt", stall_cnt, 32'(2 + i));
    end
    dmem_ready = 1;
    #1 chk("ms_release_ctl", ctl(), 8'b0000_0111);
    tick();
    chk("ms_state_run", dut.r_state, RUN);
    chk("ms_stall_cnt_end", stall_cnt, 4);
    chk("ms_flush_cnt_end", flush_cnt, 2);
    chk("ms_no_timeout", mem_timeout, 0);
    EX_branch_taken = 0; MEM_MemRead = 0; MEM_RegWrite = 0; MEM_rd = 0; EX_rs2 = 0;

    // One-cycle access: no stall, no MEM_WAIT
    MEM_MemWrite = 1; dmem_ready = 1;
    #1 chk("one_cyc_ctl", ctl(), 8'b0000_0001);
    tick();
    chk("one_cyc_state", dut.r_state, RUN);
    chk("one_cyc_stall_cnt", stall_cnt, 4);
    MEM_MemWrite = 0;

    // Timeout: ready low 6 cycles, timeout visible after 4th MEM_WAIT cycle
    MEM_MemRead = 1; dmem_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("to_flag", mem_timeout, (i >= 5) ? 1 : 0);
    end
    chk("to_stall_cnt", stall_cnt, 10);
    dmem_ready = 1;
    tick();
    chk("to_state_run", dut.r_state, RUN);
    chk("to_sticky", mem_timeout, 1);
    MEM_MemRead = 0;
    tick();
    chk("to_sticky_idle", mem_timeout, 1);

    // Stall counter saturation via load-use stalls
    EX_MemRead = 1; EX_rd = 12; ID_rs1 = 12;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("sat_stall_cnt", stall_cnt, (10 + i > 15) ? 15 : 32'(10 + i));
    end
    EX_MemRead = 0; EX_rd = 0; ID_rs1 = 0;

    // Asynchronous reset in the middle of a wait
    MEM_MemRead = 1; dmem_ready = 0;
    tick();
    tick();
    chk("mid_state_wait", dut.r_state, MEM_WAIT);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", dut.r_state, RUN);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
    chk("arst_timeout", mem_timeout, 0);
    chk("arst_wait_cnt", dut.r_wait_cnt, 0);
    idle_inputs();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_state", dut.r_state, RUN);
    chk("post_rst_stall_cnt", stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
